// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned MEM_LATENCY = 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic       {OWN_IF, OWN_DATA} arb_owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on conflict, the port that was not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       req_if_i,
    input  logic       req_d_i,
    input  arb_owner_t last_grant_i,
    output logic       gnt_if_o,
    output logic       gnt_d_o
);

    always_comb begin
        gnt_if_o = req_if_i & (~req_d_i  | (last_grant_i == OWN_DATA));
        gnt_d_o  = req_d_i  & (~req_if_i | (last_grant_i == OWN_IF));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and load/store ports.
// One transaction at a time: IDLE accepts, BUSY holds the access for LATENCY cycles, RESP pulses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
    logic              gnt_if, gnt_d;
    logic              accept;

    rr_arb2 u_rr (
        .req_if_i    (if_req_valid),
        .req_d_i     (d_req_valid),
        .last_grant_i(last_q),
        .gnt_if_o    (gnt_if),
        .gnt_d_o     (gnt_d)
    );

    // Readies are gated by rst so nothing is accepted in the reset cycle.
    assign accept       = (state_q == IDLE) & ~rst;
    assign if_req_ready = accept & gnt_if;
    assign d_req_ready  = accept & gnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_DATA;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req_ready) begin
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end else if (d_req_ready) begin
                    owner_d = OWN_DATA;
                    last_d  = OWN_DATA;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
                        else                   d_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en        = (state_q == BUSY);
        mem_we        = mem_en & we_q;
        mem_addr      = mem_en ? addr_q  : '0;
        mem_wdata     = mem_en ? wdata_q : '0;
        if_resp_valid = (state_q == RESP) & (owner_q == OWN_IF);
        d_resp_valid  = (state_q == RESP) & (owner_q == OWN_DATA);
        if_rdata      = if_rdata_q;
        d_rdata       = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, multi-cycle corner sequences,
// a LATENCY=1 instance, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LAT = 2;
    localparam logic [31:0] P_INS = 32'h0050_0093;
    localparam logic [31:0] D_ST  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        l1_if_req_valid, l1_if_req_ready, l1_if_resp_valid;
    logic [31:0] l1_if_addr, l1_if_rdata;
    logic        l1_d_req_valid, l1_d_req_ready, l1_d_we, l1_d_resp_valid;
    logic [31:0] l1_d_addr, l1_d_wdata, l1_d_rdata;
    logic        l1_mem_en, l1_mem_we;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    assign mem_rdata    = mem[mem_addr[9:2]];
    assign l1_mem_rdata = mem[l1_mem_addr[9:2]];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    mem_arbiter #(.LATENCY(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_valid(l1_if_req_valid), .if_req_ready(l1_if_req_ready), .if_addr(l1_if_addr),
        .if_resp_valid(l1_if_resp_valid), .if_rdata(l1_if_rdata),
        .d_req_valid(l1_d_req_valid), .d_req_ready(l1_d_req_ready), .d_we(l1_d_we),
        .d_addr(l1_d_addr), .d_wdata(l1_d_wdata), .d_resp_valid(l1_d_resp_valid),
        .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ifv, input logic [31:0] ifa, input logic dv,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        if_req_valid = ifv; if_addr = ifa;
        d_req_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    typedef struct {
        logic ifv; logic [31:0] ifa; logic dv; logic dwe; logic [31:0] da; logic [31:0] dwd;
        logic e_ifr; logic e_dr; logic e_en; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd;
        logic e_ifrsp; logic e_drsp; logic [31:0] e_ifrd;
    } vec_t;
    vec_t vt [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ha_t[$];
        int ha_p[$];
        int hs1[$];
        int free_at, hs_t;
        logic hs_ok, m_last, h_own, h_we, ifp, dp, rwe;
        logic idle, x_ifr, x_dr, busy_now, rsp_now;
        logic [31:0] h_addr, h_wd, h_rd, x_ifrd, x_drd, ra_if, ra_d, rwd;

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        l1_if_req_valid = 1'b0; l1_if_addr = '0;
        l1_d_req_valid = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem[4] = P_INS;

        vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[2] = vt[1];
        vt[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, P_INS};
        vt[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, D_ST,
                  1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, P_INS};
        vt[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b1, 32'h40, D_ST, 1'b0, 1'b0, P_INS};
        vt[6] = vt[5];
        vt[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, P_INS};
        vt[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, P_INS};

        do_reset();

        // Directed table: reset state, fetch then store.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vt[i].ifv, vt[i].ifa, vt[i].dv, vt[i].dwe, vt[i].da, vt[i].dwd);
            #1;
            chkb($sformatf("v%0d.if_ready", i), if_req_ready, vt[i].e_ifr);
            chkb($sformatf("v%0d.d_ready", i), d_req_ready, vt[i].e_dr);
            chkb($sformatf("v%0d.mem_en", i), mem_en, vt[i].e_en);
            chkb($sformatf("v%0d.mem_we", i), mem_we, vt[i].e_we);
            if (vt[i].e_en) begin
                chkw($sformatf("v%0d.mem_addr", i), mem_addr, vt[i].e_addr);
                chkw($sformatf("v%0d.mem_wdata", i), mem_wdata, vt[i].e_wd);
            end
            chkb($sformatf("v%0d.if_resp", i), if_resp_valid, vt[i].e_ifrsp);
            chkb($sformatf("v%0d.d_resp", i), d_resp_valid, vt[i].e_drsp);
            chkw($sformatf("v%0d.if_rdata", i), if_rdata, vt[i].e_ifrd);
        end

        // Load whose address changes while the fetch holds the memory.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                0: drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
                1: drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
                2: drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0);
                3, 4: drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
                default: drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            endcase
            #1;
            chkb($sformatf("c%0d.d_ready", k), d_req_ready, k == 4);
            if (k == 5 || k == 6) begin
                chkb($sformatf("c%0d.mem_en", k), mem_en, 1'b1);
                chkw($sformatf("c%0d.mem_addr", k), mem_addr, 32'h40);
            end
            if (k == 7) begin
                chkb("c7.d_resp", d_resp_valid, 1'b1);
                chkw("c7.d_rdata", d_rdata, D_ST);
            end
        end

        // Both ports requesting continuously from reset.
        do_reset();
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
            #1;
            chkb($sformatf("a%0d.dual_ready", t), if_req_ready & d_req_ready, 1'b0);
            if (if_req_ready) begin ha_t.push_back(t); ha_p.push_back(0); end
            if (d_req_ready)  begin ha_t.push_back(t); ha_p.push_back(1); end
        end
        chkw("a.grant_count", 32'(ha_t.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chkw($sformatf("a.grant%0d_cycle", k), (k < ha_t.size()) ? 32'(ha_t[k]) : 32'hFFFF_FFFF,
                 32'(k * 4));
            chkw($sformatf("a.grant%0d_port", k), (k < ha_p.size()) ? 32'(ha_p[k]) : 32'hFFFF_FFFF,
                 32'(k % 2));
        end

        // Reset in the middle of a load's access.
        for (int b = 0; b < 18; b++) begin
            @(negedge clk);
            rst = (b == 2);
            case (b)
                0:  drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
                2:  drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
                14: drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
                default: drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            endcase
            #1;
            if (b == 0) chkb("b0.d_ready", d_req_ready, 1'b1);
            if (b == 1) chkb("b1.mem_en", mem_en, 1'b1);
            if (b == 2) begin
                chkb("b2.if_ready_in_rst", if_req_ready, 1'b0);
                chkb("b2.d_ready_in_rst", d_req_ready, 1'b0);
            end
            if (b == 3) begin
                chkb("b3.mem_en", mem_en, 1'b0);
                chkb("b3.mem_we", mem_we, 1'b0);
                chkw("b3.mem_addr", mem_addr, 32'h0);
                chkw("b3.mem_wdata", mem_wdata, 32'h0);
                chkw("b3.if_rdata", if_rdata, 32'h0);
                chkw("b3.d_rdata", d_rdata, 32'h0);
            end
            if (b >= 3) chkb($sformatf("b%0d.d_resp", b), d_resp_valid, 1'b0);
            if (b >= 3 && b < 17) chkb($sformatf("b%0d.if_resp", b), if_resp_valid, 1'b0);
            if (b == 14) chkb("b14.if_ready", if_req_ready, 1'b1);
            if (b == 15 || b == 16) chkw($sformatf("b%0d.mem_addr", b), mem_addr, 32'h10);
            if (b == 17) begin
                chkb("b17.if_resp", if_resp_valid, 1'b1);
                chkw("b17.if_rdata", if_rdata, P_INS);
            end
        end

        // LATENCY=1 instance: back-to-back fetches.
        do_reset();
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            l1_if_req_valid = 1'b1;
            l1_if_addr = 32'h10;
            #1;
            if (l1_if_req_ready) hs1.push_back(t);
            if (t == 1) chkb("l1.mem_en_c1", l1_mem_en, 1'b1);
            if (t == 2) begin
                chkb("l1.mem_en_c2", l1_mem_en, 1'b0);
                chkb("l1.resp_c2", l1_if_resp_valid, 1'b1);
                chkw("l1.rdata_c2", l1_if_rdata, P_INS);
            end
        end
        l1_if_req_valid = 1'b0;
        chkw("l1.hs_count", 32'(hs1.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chkw($sformatf("l1.hs%0d_cycle", k), (k < hs1.size()) ? 32'(hs1[k]) : 32'hFFFF_FFFF,
                 32'(k * 3));

        // Randomized traffic against a transaction-level model.
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        ref_mem[4]  = P_INS;
        ref_mem[16] = D_ST;
        do_reset();
        free_at = 0; hs_t = 0; hs_ok = 1'b0; m_last = 1'b1;
        h_own = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0; h_rd = '0;
        x_ifrd = '0; x_drd = '0;
        ifp = 1'b0; dp = 1'b0; rwe = 1'b0; ra_if = '0; ra_d = '0; rwd = '0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (!ifp && $urandom_range(0, 99) < 35) begin
                ifp = 1'b1;
                ra_if = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end else if (ifp && $urandom_range(0, 7) == 0) begin
                ra_if = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dp && $urandom_range(0, 99) < 35) begin
                dp = 1'b1;
                ra_d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                rwe = 1'($urandom_range(0, 1));
                rwd = $urandom;
            end else if (dp && $urandom_range(0, 7) == 0) begin
                ra_d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            drive(ifp, ra_if, dp, rwe, ra_d, rwd);
            #1;
            idle     = (t >= free_at);
            x_ifr    = idle && ifp && (!dp || m_last);
            x_dr     = idle && dp && (!ifp || !m_last);
            busy_now = hs_ok && (t > hs_t) && (t <= hs_t + LAT);
            rsp_now  = hs_ok && (t == hs_t + LAT + 1);
            if (rsp_now) begin
                if (!h_own) x_ifrd = h_rd;
                else if (!h_we) x_drd = h_rd;
            end
            chkb("r.if_ready", if_req_ready, x_ifr);
            chkb("r.d_ready", d_req_ready, x_dr);
            chkb("r.mem_en", mem_en, busy_now);
            chkb("r.mem_we", mem_we, busy_now && h_we);
            if (busy_now) begin
                chkw("r.mem_addr", mem_addr, h_addr);
                if (h_we) chkw("r.mem_wdata", mem_wdata, h_wd);
            end
            chkb("r.if_resp", if_resp_valid, rsp_now && !h_own);
            chkb("r.d_resp", d_resp_valid, rsp_now && h_own);
            chkw("r.if_rdata", if_rdata, x_ifrd);
            chkw("r.d_rdata", d_rdata, x_drd);
            if (x_ifr || x_dr) begin
                hs_ok   = 1'b1;
                hs_t    = t;
                free_at = t + LAT + 2;
                h_own   = x_dr;
                m_last  = x_dr;
                h_addr  = x_dr ? ra_d : ra_if;
                h_we    = x_dr ? rwe : 1'b0;
                h_wd    = x_dr ? rwd : 32'h0;
                h_rd    = ref_mem[h_addr[9:2]];
                if (h_we) ref_mem[h_addr[9:2]] = h_wd;
            end
            if (ifp && if_req_ready) ifp = 1'b0;
            if (dp && d_req_ready) dp = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
